chip_tx_sched: RTL and testbench



---
 rtl/chip_tx_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_chip_tx_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_tx_sched.sv
// chip_tx_sched: shares one byte-wide UART between a buffered 16-bit data stream and a periodic heartbeat frame.
// Optional macro CHIP_TX_HB_CKSUM_EN appends an XOR checksum byte to every heartbeat frame.
module chip_tx_sched #(
    parameter int DEPTH = 4,
    parameter int HB_W  = 16
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic            pluse_us,
    input  logic [5:0]      dev_id,
    input  logic            cfg_en,
    input  logic [HB_W-1:0] cfg_hb_period,
    input  logic [15:0]     d_data,
    input  logic            d_vld,
    output logic            d_rdy,
    output logic [7:0]      u_data,
    output logic            u_vld,
    input  logic            u_done,
    output logic [7:0]      ovf_cnt,
    output logic            busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [2:0] DATA_LEN = 3'd2;
`ifdef CHIP_TX_HB_CKSUM_EN
    localparam logic [2:0] HB_LEN = 3'd5;
`else
    localparam logic [2:0] HB_LEN = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LOAD   = 3'd2,
        STROBE = 3'd3,
        WAIT   = 3'd4
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [15:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   fifo_cnt_r, fifo_cnt_nxt_s;
    logic            d_rdy_r;
    logic [7:0]      ovf_cnt_r;
    logic            push_s, pop_s, drop_s, fifo_ne_s;
    logic [HB_W-1:0] hb_tmr_r;
    logic            hb_pend_r, hb_on_s, hb_fire_s;
    logic [7:0]      hb_seq_r;
    logic            last_hb_r;
    logic            grant_hb_s, grant_data_s;
    logic            is_hb_r;
    logic [2:0]      byte_cnt_r, hb_idx_s;
    logic [15:0]     shift_r;
    logic [7:0]      cur_byte_s, u_data_r, u_data_nxt_s;
    logic            u_vld_r, u_vld_nxt_s, busy_r, busy_nxt_s;
    logic            frame_end_s, work_s;

`ifdef CHIP_TX_HB_CKSUM_EN
    function automatic logic [7:0] hb_cksum(input logic [5:0] id, input logic [7:0] seq);
        return {2'b00, id} ^ seq ^ 8'h5A;
    endfunction
`endif

    assign push_s      = d_vld & d_rdy_r;
    assign drop_s      = d_vld & ~d_rdy_r;
    assign pop_s       = grant_data_s;
    assign fifo_ne_s   = (fifo_cnt_r != '0);
    assign hb_on_s     = cfg_en && (cfg_hb_period != '0);
    assign hb_fire_s   = hb_on_s && pluse_us && (hb_tmr_r >= (cfg_hb_period - HB_W'(1)));
    assign work_s      = cfg_en && (fifo_ne_s || hb_pend_r);
    assign frame_end_s = (state_r == WAIT) && u_done && (byte_cnt_r == 3'd1);

    // FIFO occupancy for the next cycle
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CW'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CW'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // FIFO storage, pointers, registered ready and saturating drop counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 16'h0000;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            d_rdy_r    <= 1'b1;
            ovf_cnt_r  <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= d_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            fifo_cnt_r <= fifo_cnt_nxt_s;
            d_rdy_r    <= (fifo_cnt_nxt_s != FULL_CNT);
            if (drop_s && (ovf_cnt_r != 8'hFF)) ovf_cnt_r <= ovf_cnt_r + 8'd1;
        end
    end

    // Heartbeat timebase, pending flag and frame sequence number
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hb_tmr_r  <= '0;
            hb_pend_r <= 1'b0;
            hb_seq_r  <= 8'h00;
        end else begin
            if (!hb_on_s) hb_tmr_r <= '0;
            else if (pluse_us) hb_tmr_r <= hb_fire_s ? '0 : hb_tmr_r + HB_W'(1);
            // a request arriving in the grant cycle is a new request, so set wins over clear
            if (!cfg_en) hb_pend_r <= 1'b0;
            else if (hb_fire_s) hb_pend_r <= 1'b1;
            else if (grant_hb_s) hb_pend_r <= 1'b0;
            if (frame_end_s && is_hb_r) hb_seq_r <= hb_seq_r + 8'd1;
        end
    end

    // Round-robin grant, evaluated only in ARB
    always_comb begin
        grant_hb_s   = 1'b0;
        grant_data_s = 1'b0;
        if (state_r == ARB) begin
            if (fifo_ne_s && hb_pend_r) begin
                grant_data_s = last_hb_r;
                grant_hb_s   = ~last_hb_r;
            end else begin
                grant_data_s = fifo_ne_s;
                grant_hb_s   = hb_pend_r;
            end
        end else begin
            grant_hb_s   = 1'b0;
            grant_data_s = 1'b0;
        end
    end

    // Byte to present in LOAD, chosen from the remaining byte count
    always_comb begin
        cur_byte_s = 8'h00;
        hb_idx_s   = HB_LEN - byte_cnt_r;
        if (is_hb_r) begin
            case (hb_idx_s)
                3'd0:    cur_byte_s = 8'hA5;
                3'd1:    cur_byte_s = {2'b00, dev_id};
                3'd2:    cur_byte_s = hb_seq_r;
                3'd3:    cur_byte_s = 8'h5A;
`ifdef CHIP_TX_HB_CKSUM_EN
                3'd4:    cur_byte_s = hb_cksum(dev_id, hb_seq_r);
`endif
                default: cur_byte_s = 8'h00;
            endcase
        end else if (byte_cnt_r == DATA_LEN) begin
            cur_byte_s = shift_r[15:8];
        end else begin
            cur_byte_s = shift_r[7:0];
        end
    end

    // Transfer context: grant owner, byte countdown, data shift register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            last_hb_r  <= 1'b1;
            is_hb_r    <= 1'b0;
            byte_cnt_r <= 3'd0;
            shift_r    <= 16'h0000;
        end else begin
            if (grant_data_s) begin
                shift_r    <= mem_r[rd_ptr_r];
                byte_cnt_r <= DATA_LEN;
                is_hb_r    <= 1'b0;
                last_hb_r  <= 1'b0;
            end else if (grant_hb_s) begin
                byte_cnt_r <= HB_LEN;
                is_hb_r    <= 1'b1;
                last_hb_r  <= 1'b1;
            end else if ((state_r == WAIT) && u_done) begin
                byte_cnt_r <= byte_cnt_r - 3'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:   state_nxt_s = work_s ? ARB : IDLE;
            ARB:    state_nxt_s = (grant_data_s || grant_hb_s) ? LOAD : IDLE;
            LOAD:   state_nxt_s = STROBE;
            STROBE: state_nxt_s = WAIT;
            WAIT: begin
                if (!u_done)                  state_nxt_s = WAIT;
                else if (byte_cnt_r != 3'd1)  state_nxt_s = LOAD;
                else if (work_s)              state_nxt_s = ARB;
                else                          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so the ports come straight from flops
    always_comb begin
        u_vld_nxt_s = (state_r == LOAD);
        if (state_r == LOAD) u_data_nxt_s = cur_byte_s;
        else                 u_data_nxt_s = u_data_r;
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            u_vld_r  <= 1'b0;
            u_data_r <= 8'h00;
            busy_r   <= 1'b0;
        end else begin
            u_vld_r  <= u_vld_nxt_s;
            u_data_r <= u_data_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign d_rdy   = d_rdy_r;
    assign u_data  = u_data_r;
    assign u_vld   = u_vld_r;
    assign ovf_cnt = ovf_cnt_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_chip_tx_sched.sv
// Self-checking bench for chip_tx_sched: vector table, directed corner sequences and a randomized data stream
// compared against an ordered byte-stream reference model.
module tb_chip_tx_sched;
    localparam int DEPTH = 4;
    localparam int HB_W  = 16;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    logic            clk_sys = 1'b0;
    logic            rst_n = 1'b0;
    logic            pluse_us = 1'b0;
    logic [5:0]      dev_id = 6'h2A;
    logic            cfg_en = 1'b0;
    logic [HB_W-1:0] cfg_hb_period = '0;
    logic [15:0]     d_data = 16'h0000;
    logic            d_vld = 1'b0;
    logic            d_rdy;
    logic [7:0]      u_data;
    logic            u_vld;
    logic            u_done = 1'b0;
    logic [7:0]      ovf_cnt;
    logic            busy;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          resp_mode = 1;
    logic [7:0]  held = 8'h00;
    logic [7:0]  got[$];
    logic [7:0]  exp[$];
    int          vld_cyc[$];

    always #5 clk_sys = ~clk_sys;

    chip_tx_sched #(.DEPTH(DEPTH), .HB_W(HB_W)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .dev_id(dev_id),
        .cfg_en(cfg_en), .cfg_hb_period(cfg_hb_period), .d_data(d_data), .d_vld(d_vld),
        .d_rdy(d_rdy), .u_data(u_data), .u_vld(u_vld), .u_done(u_done),
        .ovf_cnt(ovf_cnt), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock: UART responder (resp_mode 0 withholds u_done, >0 fixed delay, <0 random) plus byte capture
    task automatic step();
        @(negedge clk_sys);
        cyc++;
        u_done = 1'b0;
        if (resp_cnt > 0) begin
            check("u_data_hold", u_data, held);
            resp_cnt--;
            if (resp_cnt == 0) u_done = 1'b1;
        end
        if (u_vld === 1'b1) begin
            got.push_back(u_data);
            vld_cyc.push_back(cyc);
            held = u_data;
            resp_cnt = (resp_mode < 0) ? int'($urandom_range(1, 3)) : resp_mode;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; d_vld = 1'b0; u_done = 1'b0; pluse_us = 1'b0; resp_cnt = 0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        got.delete(); exp.delete(); vld_cyc.delete();
    endtask

    task automatic tick();
        pluse_us = 1'b1; step(); pluse_us = 1'b0; step();
    endtask

    task automatic exp_word(input logic [15:0] w);
        exp.push_back(w[15:8]);
        exp.push_back(w[7:0]);
    endtask

    task automatic exp_hb(input logic [7:0] seq);
        exp.push_back(8'hA5);
        exp.push_back({2'b00, dev_id});
        exp.push_back(seq);
        exp.push_back(8'h5A);
`ifdef CHIP_TX_HB_CKSUM_EN
        exp.push_back({2'b00, dev_id} ^ seq ^ 8'h5A);
`endif
    endtask

    task automatic cmp_stream(input string name);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i], exp[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int   n;
        logic [15:0] w;

        vt[0] = '{16'h1234, 8'h12, 8'h34};
        vt[1] = '{16'hFFFF, 8'hFF, 8'hFF};
        vt[2] = '{16'h00A5, 8'h00, 8'hA5};
        vt[3] = '{16'h8001, 8'h80, 8'h01};

        // Reset values
        reset_dut();
        check("rst_d_rdy", d_rdy, 1'b1);
        check("rst_u_data", u_data, 8'h00);
        check("rst_u_vld", u_vld, 1'b0);
        check("rst_ovf", ovf_cnt, 8'h00);
        check("rst_busy", busy, 1'b0);

        // Single words from the vector table: latency, byte order, spacing, return to idle
        cfg_en = 1'b1; cfg_hb_period = '0; resp_mode = 1;
        for (int i = 0; i < 4; i++) begin
            got.delete(); vld_cyc.delete();
            d_data = vt[i].word; d_vld = 1'b1; step(); d_vld = 1'b0;
            n = 1;
            while (got.size() == 0 && n < 50) begin step(); n++; end
            check("latency", n, 4);
            repeat (12) step();
            check("word_bytes", got.size(), 2);
            if (got.size() == 2) begin
                check("word_hi", got[0], vt[i].hi);
                check("word_lo", got[1], vt[i].lo);
                check("byte_spacing", vld_cyc[1] - vld_cyc[0], 3);
            end
            check("idle_busy", busy, 1'b0);
        end

        // Overflow with the UART stalled, then saturation of the drop counter
        reset_dut();
        cfg_en = 1'b1; resp_mode = 0;
        for (int i = 0; i < 7; i++) begin
            d_data = {8'h10 + 8'(i), 8'h20 + 8'(i)}; d_vld = 1'b1; step();
        end
        d_vld = 1'b0; step();
        check("ovf_d_rdy", d_rdy, 1'b0);
        check("ovf_cnt2", ovf_cnt, 8'd2);
        check("ovf_bytes", got.size(), 1);
        if (got.size() >= 1) check("ovf_first", got[0], 8'h10);
        check("ovf_busy", busy, 1'b1);
        d_vld = 1'b1; repeat (253) step(); d_vld = 1'b0; step();
        check("ovf_cnt255", ovf_cnt, 8'hFF);
        d_vld = 1'b1; repeat (5) step(); d_vld = 1'b0; step();
        check("ovf_sat", ovf_cnt, 8'hFF);
        check("ovf_d_rdy2", d_rdy, 1'b0);

        // Asynchronous reset while waiting for u_done
        @(posedge clk_sys); #2 rst_n = 1'b0;
        #1;
        check("arst_u_vld", u_vld, 1'b0);
        check("arst_u_data", u_data, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_d_rdy", d_rdy, 1'b1);
        check("arst_ovf", ovf_cnt, 8'h00);
        @(negedge clk_sys); rst_n = 1'b1;
        got.delete();
        u_done = 1'b1; step();
        repeat (10) step();
        check("arst_no_tx", got.size(), 0);
        check("arst_idle", busy, 1'b0);

        // Heartbeat frames: period 10, 30 ticks
        reset_dut();
        cfg_en = 1'b1; cfg_hb_period = 16'd10; resp_mode = -1;
        for (int t = 0; t < 30; t++) begin
            pluse_us = 1'b1; step(); pluse_us = 1'b0;
            repeat (9) step();
        end
        repeat (40) step();
        exp_hb(8'h00); exp_hb(8'h01); exp_hb(8'h02);
        cmp_stream("hb_frames");

        // Fairness: three words plus a heartbeat request from IDLE
        reset_dut();
        cfg_en = 1'b0; cfg_hb_period = 16'd1; resp_mode = -1;
        d_vld = 1'b1;
        d_data = 16'hC1C2; step();
        d_data = 16'hD1D2; step();
        d_data = 16'hE1E2; step();
        d_vld = 1'b0;
        cfg_en = 1'b1; pluse_us = 1'b1; step(); pluse_us = 1'b0;
        repeat (60) step();
        exp_word(16'hC1C2); exp_hb(8'h00); exp_word(16'hD1D2); exp_word(16'hE1E2);
        cmp_stream("fair");

        // cfg_en dropped mid-frame: frame completes, pending request and timer are cleared
        reset_dut();
        cfg_en = 1'b1; cfg_hb_period = 16'd2; resp_mode = 2;
        tick(); tick();
        n = 0;
        while (got.size() < 1 && n < 50) begin step(); n++; end
        tick(); tick(); tick();
        cfg_en = 1'b0;
        repeat (40) step();
        exp_hb(8'h00);
        cmp_stream("drop_frame");
        check("drop_idle", busy, 1'b0);
        cfg_en = 1'b1;
        tick();
        repeat (15) step();
        cmp_stream("drop_restart");
        tick();
        repeat (40) step();
        exp_hb(8'h01);
        cmp_stream("drop_reenable");

        // Randomized data stream against the ordered byte model
        reset_dut();
        cfg_en = 1'b1; cfg_hb_period = '0; resp_mode = -1;
        for (int c = 0; c < 600; c++) begin
            d_vld = d_rdy && ($urandom_range(0, 2) == 0);
            w = 16'($urandom());
            d_data = w;
            if (d_vld) exp_word(w);
            step();
        end
        d_vld = 1'b0;
        repeat (300) step();
        cmp_stream("random");
        check("random_ovf", ovf_cnt, 8'h00);
        check("random_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
